// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 8-digit seven-segment scan scheduler with frame-aligned value commit
module display_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        wr_valid_i,
  input  logic [31:0] wr_data_i,
  output logic        wr_ready_o,
  input  logic        lz_en_i,
  output logic [7:0]  anode_o,
  output logic [2:0]  digit_sel_o,
  output logic [3:0]  nibble_o,
  output logic        frame_start_o
);
  localparam int MAXC = PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES;
  localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] SHOW_LAST = TW'(PRESCALE - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   active_q, active_d, pending_q, pending_d;
  logic          pend_v_q, pend_v_d;
  logic [7:0]    anode_q, anode_d;
  logic [3:0]    nibble_q, nibble_d;
  logic          frame_q, frame_d;
  logic          show_end, blank_end, commit, accept, suppress;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q   <= BLANK;
      timer_q   <= '0;
      digit_q   <= 3'd7;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      anode_q   <= 8'hFF;
      nibble_q  <= '0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      digit_q   <= digit_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      anode_q   <= anode_d;
      nibble_q  <= nibble_d;
      frame_q   <= frame_d;
    end
  // Commit and accept are mutually exclusive: commit needs a full buffer, accept an empty one.
  always_comb begin
    show_end  = state_q == SHOW && timer_q == SHOW_LAST;
    blank_end = state_q == BLANK && timer_q == BLANK_LAST;
    state_d   = show_end ? BLANK : blank_end ? SHOW : state_q;
    timer_d   = (show_end || blank_end) ? '0 : timer_q + 1'b1;
    digit_d   = blank_end ? digit_q + 3'd1 : digit_q;
    commit    = blank_end && digit_q == 3'd7 && pend_v_q;
    accept    = wr_valid_i && !pend_v_q;
    active_d  = commit ? pending_q : active_q;
    pending_d = accept ? wr_data_i : pending_q;
    pend_v_d  = accept ? 1'b1 : commit ? 1'b0 : pend_v_q;
  end
  always_comb begin
    suppress = lz_en_i && digit_d != 3'd0 && (active_d >> {digit_d, 2'b00}) == 32'd0;
    anode_d  = show_end ? 8'hFF : blank_end ? (suppress ? 8'hFF : ~(8'd1 << digit_d)) : anode_q;
    nibble_d = active_d[{digit_d, 2'b00} +: 4];
    frame_d  = blank_end && digit_q == 3'd7;
  end
  assign wr_ready_o    = !pend_v_q;
  assign anode_o       = anode_q;
  assign digit_sel_o   = digit_q;
  assign nibble_o      = nibble_q;
  assign frame_start_o = frame_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench with a time-indexed scan model for display_scan_ctrl
module tb_display_scan_ctrl;
  localparam int P = 4;
  localparam int B = 2;
  localparam int DP = P + B;
  localparam int FP = 8 * DP;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        lz_en = 1'b0;
  logic        wr_ready;
  logic [7:0]  anode;
  logic [2:0]  digit_sel;
  logic [3:0]  nibble;
  logic        frame_start;
  int          n_chk = 0;
  int          n_fail = 0;
  int          e = 0;
  logic        m_pv = 1'b0;
  logic        m_lz = 1'b0;
  logic        acc_flag = 1'b0;
  logic [31:0] m_active = '0;
  logic [31:0] q[$];

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clock_i(clk), .reset_i(rst), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready), .lz_en_i(lz_en), .anode_o(anode), .digit_sel_o(digit_sel),
    .nibble_o(nibble), .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs follow from the edge count since reset release.
  initial begin
    logic v, lz, r, bnd, cm, ac, show, fs;
    logic [31:0] d;
    logic [7:0] exp_an;
    int u, dig;
    forever begin
      @(posedge clk);
      v = wr_valid; d = wr_data; lz = lz_en; r = rst;
      #1;
      acc_flag = 1'b0;
      if (r) begin
        e = 0; m_pv = 1'b0; m_active = '0; m_lz = 1'b0; q.delete();
      end else begin
        e++;
        bnd = e >= B && (e - B) % FP == 0;
        cm = bnd && m_pv;
        ac = v && !m_pv;
        if (cm) begin m_active = q.pop_front(); m_pv = 1'b0; end
        if (ac) begin q.push_back(d); m_pv = 1'b1; acc_flag = 1'b1; end
        if (e >= B && (e - B) % DP == 0) m_lz = lz;
      end
      if (e < B) begin
        dig = 7; show = 1'b0; fs = 1'b0;
      end else begin
        u = e - B;
        dig = (u / DP) % 8; show = (u % DP) < P; fs = (u % FP) == 0;
      end
      exp_an = 8'hFF;
      if (show && !(m_lz && dig != 0 && (m_active >> (4 * dig)) == 32'd0))
        exp_an = ~(8'd1 << dig);
      check("anode", {24'd0, anode}, {24'd0, exp_an});
      check("digit_sel", {29'd0, digit_sel}, dig);
      check("nibble", {28'd0, nibble}, {28'd0, m_active[4 * dig +: 4]});
      check("frame_start", {31'd0, frame_start}, {31'd0, fs});
      check("wr_ready", {31'd0, wr_ready}, {31'd0, !m_pv});
    end
  end

  task automatic wait_pos(input int p);
    logic found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (e >= B && (e - B) % FP == p) found = 1'b1;
      else begin @(posedge clk); #2; end
    end
    check("wait_pos_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic write(input logic [31:0] val);
    logic ok = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data = val;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #2;
      ok = acc_flag;
    end
    check("write_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(60);
    wait_pos(10);
    write(32'h8765_4321);
    idle(100);
    wait_pos(20);
    write(32'hA5A5_0F0F);
    write(32'h1357_9BDF);
    idle(120);
    write(32'h0000_0040);
    lz_en = 1'b1;
    idle(110);
    write(32'h0000_0000);
    idle(110);
    lz_en = 1'b0;
    wait_pos(FP - 1);
    write(32'hCAFE_F00D);
    idle(110);
    wait_pos(5);
    write(32'hDEAD_BEEF);
    idle(0);
    wait_pos(31);
    #1 rst = 1'b1;
    #1;
    check("rst_anode", {24'd0, anode}, 32'h0000_00FF);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_digit", {29'd0, digit_sel}, 32'd7);
    check("rst_nibble", {28'd0, nibble}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
